// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// The loader sits on the slave side; the stream source/memory/core on master.
interface imem_loader_if;
  logic        Start;
  logic        ByteValid;
  logic [7:0]  ByteData;
  logic        ByteReady;
  logic        WrEnable;
  logic [31:0] WrAddress;
  logic [31:0] WrData;
  logic        CoreHold;
  logic        Busy;
  logic        Done;
  logic        Error;

  modport slave (
    input  Start, ByteValid, ByteData,
    output ByteReady, WrEnable, WrAddress, WrData, CoreHold, Busy, Done, Error
  );

  modport master (
    output Start, ByteValid, ByteData,
    input  ByteReady, WrEnable, WrAddress, WrData, CoreHold, Busy, Done, Error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a 16-bit little-endian word
// count followed by little-endian instruction bytes, assembles 32-bit words
// and writes them to consecutive word addresses while holding the core reset.
module imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic         Clk,
  input  logic         Reset,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state, state_nxt;
  logic [15:0] n_words;
  logic [15:0] idx;
  logic [1:0]  cnt;
  // Only bytes 0..2 are kept here; byte 3 goes straight into the write word.
  logic [23:0] asm_word;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic        byte_ready;
  logic        wr_en;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;

  logic        accept;
  logic        start_ok;
  logic [15:0] n_full;
  logic        len_ok;
  logic        last_word;

  assign accept    = bus.ByteValid && byte_ready;
  assign start_ok  = bus.Start && ((state == IDLE) || (state == ERR));
  assign n_full    = {bus.ByteData, n_words[7:0]};
  assign len_ok    = (n_full != 16'd0) && ({1'b0, n_full} <= DEPTH_W);
  assign last_word = (idx == (n_words - 16'd1));

  // State register; reset aborts any load in progress.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and outputs decoded purely from the current state.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    core_hold  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.Start) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        core_hold  = 1'b1;
        if (accept) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        core_hold  = 1'b1;
        if (accept) state_nxt = len_ok ? DATA : ERR;
      end
      DATA: begin
        byte_ready = 1'b1;
        core_hold  = 1'b1;
        if (accept && (cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        core_hold = 1'b1;
        state_nxt = last_word ? DONE : DATA;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        err       = 1'b1;
        core_hold = 1'b1;
        if (bus.Start) state_nxt = LEN_LO;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Header capture, word assembly, write-port registers and word index.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      n_words  <= 16'd0;
      idx      <= 16'd0;
      cnt      <= 2'd0;
      asm_word <= 24'd0;
      wr_addr  <= 32'd0;
      wr_data  <= 32'd0;
    end else begin
      if (start_ok) begin
        idx <= 16'd0;
        cnt <= 2'd0;
      end
      case (state)
        LEN_LO: if (accept) n_words[7:0]  <= bus.ByteData;
        LEN_HI: if (accept) n_words[15:8] <= bus.ByteData;
        DATA: begin
          if (accept) begin
            cnt <= cnt + 2'd1;
            case (cnt)
              2'd0: asm_word[7:0]   <= bus.ByteData;
              2'd1: asm_word[15:8]  <= bus.ByteData;
              2'd2: asm_word[23:16] <= bus.ByteData;
              default: begin
                // Present the finished word during the WRITE cycle that follows.
                wr_data <= {bus.ByteData, asm_word};
                wr_addr <= {14'd0, idx, 2'b00};
              end
            endcase
          end
        end
        WRITE: if (!last_word) idx <= idx + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.ByteReady = byte_ready;
  assign bus.WrEnable  = wr_en;
  assign bus.WrAddress = wr_addr;
  assign bus.WrData    = wr_data;
  assign bus.CoreHold  = core_hold;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.Error     = err;

endmodule
